// File: rtl/systolic_result_drain_if.sv
// Capture and stream bundle for systolic_result_drain: a whole-matrix snapshot
// handshake on the input side and a one-element-per-beat valid/ready stream on the output side.
interface systolic_result_drain_if #(
  parameter int N  = 16,
  parameter int CW = 16
);
  localparam int LW = $clog2(N);

  logic                cap_valid;
  logic                cap_ready;
  logic [N*N*CW-1:0]   c_flat;
  logic [CW-1:0]       out_data;
  logic [LW-1:0]       out_row;
  logic [LW-1:0]       out_col;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic                busy;
  logic                done;

  // Environment side: offers snapshots and sinks the stream.
  modport master (
    output cap_valid, c_flat, out_ready,
    input  cap_ready, out_data, out_row, out_col, out_valid, out_last, busy, done
  );

  // Drain side.
  modport slave (
    input  cap_valid, c_flat, out_ready,
    output cap_ready, out_data, out_row, out_col, out_valid, out_last, busy, done
  );
endinterface

// File: rtl/systolic_result_drain.sv
// Snapshots an NxN result matrix in one handshake and streams it out one element per beat.
// Define DRAIN_COLMAJOR_EN for column-major order (row-major otherwise).
module systolic_result_drain #(
  parameter int N  = 16,
  parameter int CW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  systolic_result_drain_if.slave bus
);
  localparam int LW = $clog2(N);
  localparam int IW = 2 * LW;
  localparam int NE = N * N;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t          state;
  logic [CW-1:0]   bank [NE];

  logic [IW-1:0]   idx_p1;
  logic [CW-1:0]   data_p1;
  logic [LW-1:0]   row_p1;
  logic [LW-1:0]   col_p1;
  logic            vld_p1;
  logic            last_p1;
  logic            done_p1;

  logic [IW-1:0]   nxt_idx;
  logic [LW-1:0]   nxt_row;
  logic [LW-1:0]   nxt_col;
  logic [IW-1:0]   nxt_addr;
  logic            cap_rdy;
  logic            accept;
  logic            capture;

  // Next-beat coordinates are a plain bit split of the beat index.
  always_comb begin
    nxt_idx = idx_p1 + IW'(1);
`ifdef DRAIN_COLMAJOR_EN
    nxt_col = nxt_idx[IW-1:LW];
    nxt_row = nxt_idx[LW-1:0];
`else
    nxt_row = nxt_idx[IW-1:LW];
    nxt_col = nxt_idx[LW-1:0];
`endif
    nxt_addr = {nxt_row, nxt_col};
  end

  // A new snapshot may land on the very edge that retires the last beat.
  assign cap_rdy = (state == IDLE) || (last_p1 && bus.out_ready);
  assign accept  = vld_p1 && bus.out_ready;
  assign capture = bus.cap_valid && cap_rdy;

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int e = 0; e < NE; e++) begin
        bank[e] <= bus.c_flat[e*CW +: CW];
      end
    end
  end

  // ---- stage p1: registered beat presented to the stream ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      done_p1 <= 1'b0;
      idx_p1  <= '0;
      data_p1 <= '0;
      row_p1  <= '0;
      col_p1  <= '0;
    end else begin
      done_p1 <= accept && last_p1;
      if (capture) begin
        state   <= STREAM;
        vld_p1  <= 1'b1;
        last_p1 <= 1'b0;
        idx_p1  <= '0;
        data_p1 <= bus.c_flat[CW-1:0];
        row_p1  <= '0;
        col_p1  <= '0;
      end else if (accept) begin
        if (last_p1) begin
          state   <= IDLE;
          vld_p1  <= 1'b0;
          last_p1 <= 1'b0;
        end else begin
          idx_p1  <= nxt_idx;
          data_p1 <= bank[nxt_addr];
          row_p1  <= nxt_row;
          col_p1  <= nxt_col;
          last_p1 <= &nxt_idx;
        end
      end
    end
  end

  assign bus.cap_ready = cap_rdy;
  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_row   = row_p1;
  assign bus.out_col   = col_p1;
  assign bus.out_last  = last_p1;
  assign bus.busy      = (state == STREAM);
  assign bus.done      = done_p1;
endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: table of checkpoint beats plus hand-written
// sequences for backpressure, snapshot isolation, back-to-back capture, reset and refusal.
module tb_systolic_result_drain;
  localparam int N  = 16;
  localparam int CW = 16;
  localparam int NE = N * N;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_result_drain_if #(.N(N), .CW(CW)) bus ();
  systolic_result_drain #(.N(N), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic [CW-1:0] got_data [NE];
  logic [3:0]    got_row  [NE];
  logic [3:0]    got_col  [NE];
  logic          got_last [NE];
  int nbeats, stall_bad, busy_low, crdy_bad;

  typedef struct {
    int beat;
    int data;
    int r_rm;
    int c_rm;
    bit last;
  } vec_t;
  vec_t vecs [6];

  function automatic int exp_row(int k);
`ifdef DRAIN_COLMAJOR_EN
    return k % N;
`else
    return k / N;
`endif
  endfunction

  function automatic int exp_col(int k);
`ifdef DRAIN_COLMAJOR_EN
    return k / N;
`else
    return k % N;
`endif
  endfunction

  function automatic int pat(int r, int c);
    return 16 * (r + 1) * (c + 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_pattern();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        bus.c_flat[(r*N+c)*CW +: CW] = CW'(pat(r, c));
  endtask

  task automatic load_const(input logic [CW-1:0] v);
    for (int e = 0; e < NE; e++) bus.c_flat[e*CW +: CW] = v;
  endtask

  // Entered and left #1 after a rising edge; beat 0 is presented on return.
  task automatic capture(input string name);
    bus.cap_valid = 1'b1;
    #1;
    check({name, "_cap_ready"}, bus.cap_ready, 1);
    @(posedge clk); #1;
    bus.cap_valid = 1'b0;
    check({name, "_beat0_valid"}, bus.out_valid, 1);
  endtask

  // Collects beats until the last one is accepted; returns #1 after that edge.
  task automatic run_drain(input bit rnd, input int budget, output int ncyc);
    logic [CW-1:0] hd;
    logic [3:0]    hr, hc;
    logic          hl;
    bit            held, rdy;
    nbeats = 0; stall_bad = 0; busy_low = 0; crdy_bad = 0;
    held = 0; hd = '0; hr = '0; hc = '0; hl = 1'b0;
    ncyc = budget;
    for (int c = 0; c < budget; c++) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = rdy;
      #1;
      if (bus.busy !== 1'b1) busy_low++;
      if (bus.cap_ready !== (bus.out_last & rdy)) crdy_bad++;
      if (held && (bus.out_data !== hd || bus.out_row !== hr ||
                   bus.out_col !== hc || bus.out_last !== hl)) stall_bad++;
      if (bus.out_valid === 1'b1) begin
        if (rdy) begin
          if (nbeats < NE) begin
            got_data[nbeats] = bus.out_data;
            got_row[nbeats]  = bus.out_row;
            got_col[nbeats]  = bus.out_col;
            got_last[nbeats] = bus.out_last;
          end
          nbeats++;
          held = 0;
        end else begin
          held = 1;
          hd = bus.out_data; hr = bus.out_row; hc = bus.out_col; hl = bus.out_last;
        end
      end
      if (bus.out_valid === 1'b1 && rdy && bus.out_last === 1'b1) begin
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        ncyc = c + 1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic verify_stream(input string name, input bit constant7);
    int errs, sum, lasts, ev;
    errs = 0; sum = 0; lasts = 0;
    check({name, "_nbeats"}, nbeats, NE);
    for (int k = 0; k < NE; k++) begin
      ev = constant7 ? 7 : pat(exp_row(k), exp_col(k));
      if (got_data[k] !== CW'(ev)) errs++;
      if (got_row[k] !== 4'(exp_row(k)) || got_col[k] !== 4'(exp_col(k))) errs++;
      if (got_last[k] !== (k == NE - 1)) errs++;
      if (got_last[k] === 1'b1) lasts++;
      sum += int'(got_data[k]);
    end
    check({name, "_beat_errors"}, errs, 0);
    check({name, "_last_count"}, lasts, 1);
    check({name, "_sum"}, sum, constant7 ? 7 * NE : 295936);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_out_valid"}, bus.out_valid, 0);
    check({name, "_out_last"},  bus.out_last, 0);
    check({name, "_out_data"},  bus.out_data, 0);
    check({name, "_out_row"},   bus.out_row, 0);
    check({name, "_out_col"},   bus.out_col, 0);
    check({name, "_busy"},      bus.busy, 0);
    check({name, "_done"},      bus.done, 0);
    check({name, "_cap_ready"}, bus.cap_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ncyc, er, ec, errs;

    vecs[0] = '{0,   16,   0,  0,  1'b0};
    vecs[1] = '{1,   32,   0,  1,  1'b0};
    vecs[2] = '{16,  32,   1,  0,  1'b0};
    vecs[3] = '{17,  64,   1,  1,  1'b0};
    vecs[4] = '{100, 560,  6,  4,  1'b0};
    vecs[5] = '{255, 4096, 15, 15, 1'b1};

    bus.cap_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.c_flat    = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");

    // Test 1: basic drain, checkpoint table.
    load_pattern();
    capture("t1");
    run_drain(1'b0, 400, ncyc);
    check("t1_cycles", ncyc, NE);
    check("t1_done", bus.done, 1);
    check("t1_idle_valid", bus.out_valid, 0);
    check("t1_idle_busy", bus.busy, 0);
    for (int i = 0; i < 6; i++) begin
`ifdef DRAIN_COLMAJOR_EN
      er = vecs[i].c_rm; ec = vecs[i].r_rm;
`else
      er = vecs[i].r_rm; ec = vecs[i].c_rm;
`endif
      check($sformatf("t1_beat%0d_data", vecs[i].beat), got_data[vecs[i].beat], vecs[i].data);
      check($sformatf("t1_beat%0d_row", vecs[i].beat), got_row[vecs[i].beat], er);
      check($sformatf("t1_beat%0d_col", vecs[i].beat), got_col[vecs[i].beat], ec);
      check($sformatf("t1_beat%0d_last", vecs[i].beat), got_last[vecs[i].beat], vecs[i].last);
    end
    verify_stream("t1", 1'b0);
    check("t1_cap_ready_stream", crdy_bad, 0);
    @(posedge clk); #1;
    check("t1_done_one_cycle", bus.done, 0);

    // Test 2: random backpressure.
    load_pattern();
    capture("t2");
    run_drain(1'b1, 3000, ncyc);
    verify_stream("t2", 1'b0);
    check("t2_stall_stable", stall_bad, 0);
    check("t2_cap_ready_stream", crdy_bad, 0);
    check("t2_done", bus.done, 1);
    @(posedge clk); #1;

    // Test 3: c_flat changes one cycle after capture.
    load_pattern();
    capture("t3");
    @(posedge clk); #1;
    bus.c_flat = '1;
    run_drain(1'b0, 400, ncyc);
    verify_stream("t3", 1'b0);
    @(posedge clk); #1;

    // Test 4: back-to-back capture on the last-beat edge.
    load_pattern();
    capture("t4");
    load_const(16'h0007);
    bus.cap_valid = 1'b1;
    run_drain(1'b0, 400, ncyc);
    verify_stream("t4_first", 1'b0);
    check("t4_busy_first", busy_low, 0);
    check("t4_cap_ready_first", crdy_bad, 0);
    check("t4_done", bus.done, 1);
    check("t4_next_valid", bus.out_valid, 1);
    check("t4_next_data", bus.out_data, 7);
    check("t4_next_row", bus.out_row, 0);
    check("t4_next_col", bus.out_col, 0);
    check("t4_busy_between", bus.busy, 1);
    bus.cap_valid = 1'b0;
    run_drain(1'b0, 400, ncyc);
    verify_stream("t4_second", 1'b1);
    check("t4_busy_second", busy_low, 0);
    check("t4_done_second", bus.done, 1);
    @(posedge clk); #1;

    // Test 5: reset after beat 100 is accepted.
    load_pattern();
    capture("t5");
    bus.out_ready = 1'b1;
    repeat (101) @(posedge clk);
    #1;
    check("t5_beat101_data", bus.out_data, 672);
    rst = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state("t5_reset");
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_beats", bus.out_valid, 0);
    capture("t5_re");
    check("t5_restart_data", bus.out_data, 16);
    check("t5_restart_row", bus.out_row, 0);
    check("t5_restart_col", bus.out_col, 0);
    run_drain(1'b0, 400, ncyc);
    verify_stream("t5_re", 1'b0);
    @(posedge clk); #1;

    // Test 6: capture refused while streaming and stalled.
    load_pattern();
    capture("t6");
    bus.out_ready = 1'b0;
    load_const(16'h0007);
    bus.cap_valid = 1'b1;
    errs = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (bus.cap_ready !== 1'b0) errs++;
      @(posedge clk); #1;
    end
    check("t6_cap_ready_low", errs, 0);
    check("t6_held_data", bus.out_data, 16);
    check("t6_held_col", bus.out_col, 0);
    bus.cap_valid = 1'b0;
    run_drain(1'b0, 400, ncyc);
    verify_stream("t6", 1'b0);
    @(posedge clk); #1;
    check("t6_idle_after", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
